// File: rtl/mc_control_unit_if.sv
// Control-unit bus: instruction fields and memory handshake in, datapath strobes and selects out.
interface mc_control_unit_if #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned ALUOP_W = 3
);
    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_read;
    logic               mem_write;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               illegal_op;
    logic [3:0]         state;

    // Control unit side
    modport master (
        input  op, funct, mem_ready,
        output mem_req, mem_read, mem_write, iord, ir_write, pc_write,
               pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
               reg_write, reg_dst, mem_to_reg, illegal_op, state
    );

    // Datapath side
    modport slave (
        output op, funct, mem_ready,
        input  mem_req, mem_read, mem_write, iord, ir_write, pc_write,
               pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
               reg_write, reg_dst, mem_to_reg, illegal_op, state
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: fetch/decode/execute/memory/write-back FSM
// with a memory ready handshake. Outputs are combinational from state.
// Optional feature macro: MC_JUMP_LINK_EN enables jal and jr (JAL/JR states).
module mc_control_unit #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    mc_control_unit_if.master bus
);
    localparam logic [OP_W-1:0]    OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]    OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]    OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]    OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0]    OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0]    OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]    OP_J     = OP_W'(6'b000010);
`ifdef MC_JUMP_LINK_EN
    localparam logic [OP_W-1:0]    OP_JAL   = OP_W'(6'b000011);
`endif
    localparam logic [FUNCT_W-1:0] FN_JR    = FUNCT_W'(6'b001000);

    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_ADDI  = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_ANDI  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b110);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t decode_next;
    logic   decode_legal;

    // State register, synchronous reset back to FETCH from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode decode: dispatch target out of DECODE and legality flag
    always_comb begin
        decode_next  = S_FETCH;
        decode_legal = 1'b1;
        case (bus.op)
            OP_RTYPE: begin
                if (bus.funct == FN_JR) begin
`ifdef MC_JUMP_LINK_EN
                    decode_next  = S_JR;
`else
                    decode_legal = 1'b0;
`endif
                end else begin
                    decode_next = S_EXEC;
                end
            end
            OP_LW, OP_SW:     decode_next = S_MEM_ADDR;
            OP_ADDI, OP_ANDI: decode_next = S_IMM_EXEC;
            OP_BEQ:           decode_next = S_BRANCH;
            OP_J:             decode_next = S_JUMP;
`ifdef MC_JUMP_LINK_EN
            OP_JAL:           decode_next = S_JAL;
`endif
            default:          decode_legal = 1'b0;
        endcase
    end

    // Next-state logic; memory states hold until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next;
            S_MEM_ADDR: state_d = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_ALU_WB;
            S_IMM_EXEC: state_d = S_IMM_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode from state; everything held at zero during reset
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = '0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.illegal_op    = 1'b0;
        bus.state         = 4'd0;
        if (!rst) begin
            bus.state = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = ALU_ADD;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b  = 2'b11;
                    bus.alu_op     = ALU_ADD;
                    bus.illegal_op = !decode_legal;
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 2'b01;
                end
                S_MEM_WR: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_FUNCT;
                end
                S_ALU_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 2'b01;
                end
                S_IMM_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = (bus.op == OP_ADDI) ? ALU_ADDI : ALU_ANDI;
                end
                S_IMM_WB: begin
                    bus.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                end
`ifdef MC_JUMP_LINK_EN
                S_JAL: begin
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 2'b10;
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 2'b10;
                    bus.mem_to_reg = 2'b10;
                end
                S_JR: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b11;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: expected output vectors per cycle are
// queued as stimulus is driven and popped when the DUT outputs are sampled.
module tb_mc_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {7'b0, bus.mem_req, bus.mem_read, bus.mem_write, bus.iord,
                bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_source,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.illegal_op, bus.state};
    endfunction

    function automatic bit bench_legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: begin
`ifdef MC_JUMP_LINK_EN
                return 1'b1;
`else
                return f != 6'b001000;
`endif
            end
            6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b000100, 6'b000010: return 1'b1;
`ifdef MC_JUMP_LINK_EN
            6'b000011: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Expected outputs for a state, straight from the per-state output table
    function automatic logic [31:0] exp_vec(input int st, input bit rdy,
                                            input logic [5:0] o, input logic [5:0] f);
        logic mreq, mrd, mwr, io, irw, pcw, pcwc, asa, rw, ill;
        logic [1:0] pcs, asb, rd, m2r;
        logic [2:0] aop;
        {mreq, mrd, mwr, io, irw, pcw, pcwc, asa, rw, ill} = '0;
        {pcs, asb, rd, m2r} = '0;
        aop = 3'b000;
        case (st)
            0:  begin mreq = 1; mrd = 1; asb = 2'b01; aop = 3'b001; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'b11; aop = 3'b001; ill = !bench_legal(o, f); end
            2:  begin asa = 1; asb = 2'b10; aop = 3'b001; end
            3:  begin mreq = 1; mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin mreq = 1; mwr = 1; io = 1; end
            6:  begin asa = 1; aop = 3'b000; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin asa = 1; aop = 3'b110; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; aop = (o == 6'b001000) ? 3'b010 : 3'b011; end
            11: begin rw = 1; end
            12: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
            13: begin pcw = 1; pcs = 2'b11; end
            default: ;
        endcase
        return {7'b0, mreq, mrd, mwr, io, irw, pcw, pcwc, pcs, asa, asb, aop,
                rw, rd, m2r, ill, 4'(st)};
    endfunction

    // One cycle: drive inputs, queue the expectation, sample away from the edge
    task automatic step(input int st, input bit rdy, input logic [5:0] o, input logic [5:0] f);
        logic [31:0] exp;
        @(negedge clk);
        bus.op        = o;
        bus.funct     = f;
        bus.mem_ready = rdy;
        sb.push_back(exp_vec(st, rdy, o, f));
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check($sformatf("st%0d_op%02h", st, o), dut_vec(), exp);
        end
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Full instruction: fw FETCH stalls, mw stalls in the data memory state
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
        for (int i = 0; i < fw; i++) step(0, 1'b0, o, f);
        step(0, 1'b1, o, f);
        step(1, rnd(), o, f);
        if (bench_legal(o, f)) begin
            case (o)
                6'b100011: begin
                    step(2, rnd(), o, f);
                    for (int i = 0; i < mw; i++) step(3, 1'b0, o, f);
                    step(3, 1'b1, o, f);
                    step(4, rnd(), o, f);
                end
                6'b101011: begin
                    step(2, rnd(), o, f);
                    for (int i = 0; i < mw; i++) step(5, 1'b0, o, f);
                    step(5, 1'b1, o, f);
                end
                6'b000000: begin
                    if (f == 6'b001000) begin
                        step(13, rnd(), o, f);
                    end else begin
                        step(6, rnd(), o, f);
                        step(7, rnd(), o, f);
                    end
                end
                6'b001000, 6'b001100: begin
                    step(10, rnd(), o, f);
                    step(11, rnd(), o, f);
                end
                6'b000100: step(8, rnd(), o, f);
                6'b000010: step(9, rnd(), o, f);
                6'b000011: step(12, rnd(), o, f);
                default: ;
            endcase
        end
    endtask

    // Reset pulse of two edges: outputs forced zero, then FETCH request on release
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        #1 check("rst_force", dut_vec(), 32'd0);
        @(negedge clk);
        #1 check("rst_hold", dut_vec(), 32'd0);
        rst = 1'b0;
        #1 check("rst_release", dut_vec(), exp_vec(0, 1'b0, bus.op, bus.funct));
    endtask

    initial begin
        bus.op        = 6'b0;
        bus.funct     = 6'b0;
        bus.mem_ready = 1'b0;
        do_reset();
        run_instr(6'b000000, 6'b100000, 0, 0);  // R-type add
        run_instr(6'b100011, 6'b000000, 0, 3);  // lw, 3 wait cycles
        run_instr(6'b000100, 6'b000000, 0, 0);  // beq
        run_instr(6'b101011, 6'b000000, 1, 2);  // sw with fetch stall
        run_instr(6'b001000, 6'b000000, 2, 0);  // addi
        run_instr(6'b001100, 6'b000000, 0, 0);  // andi
        run_instr(6'b000010, 6'b000000, 0, 0);  // j
        run_instr(6'b000011, 6'b000000, 0, 0);  // jal (illegal without link)
        run_instr(6'b000000, 6'b001000, 0, 0);  // jr (illegal without link)
        run_instr(6'b111111, 6'b000000, 0, 0);  // unsupported opcode
        run_instr(6'b100011, 6'b000000, 0, 0);  // lw zero wait
        // sw stalled in MEM_WR, then reset mid-access
        step(0, 1'b1, 6'b101011, 6'b0);
        step(1, 1'b0, 6'b101011, 6'b0);
        step(2, 1'b0, 6'b101011, 6'b0);
        step(5, 1'b0, 6'b101011, 6'b0);
        do_reset();
        run_instr(6'b000000, 6'b100010, 1, 0);  // R-type sub after reset
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
